// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory controller.
package data_mem_pkg;

  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, DOUBLE = 2'b11} mem_size_e;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} ctrl_state_e;

  localparam int CNT_W = 4;

  // Offset bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_mask(mem_size_e size);
    case (size)
      BYTE:    return 3'b000;
      HALF:    return 3'b001;
      WORD:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Byte-lane enables for an access of the given size starting at lane off.
  function automatic logic [7:0] byte_en(mem_size_e size, logic [2:0] off);
    logic [7:0] m;
    case (size)
      BYTE:    m = 8'h01;
      HALF:    m = 8'h03;
      WORD:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/data_mem_extract.sv
// Load-path lane select with sign/zero extension to the full data width.
module data_mem_extract
  import data_mem_pkg::*;
#(
  parameter  int DATA_WIDTH_POW = 6,
  localparam int DW             = 2**DATA_WIDTH_POW,
  localparam int BOFF           = DATA_WIDTH_POW - 3
) (
  input  logic [DW-1:0]   word,
  input  logic [BOFF-1:0] off,
  input  mem_size_e       size,
  input  logic            is_unsigned,
  output logic [DW-1:0]   data
);

  logic [DW-1:0] sh;
  logic [DW-1:0] keep;
  logic          sgn;

  assign sh = word >> {off, 3'b000};

  always_comb begin
    keep = '1;
    sgn  = 1'b0;
    case (size)
      BYTE:    begin keep = DW'(64'hFF);        sgn = sh[7];  end
      HALF:    begin keep = DW'(64'hFFFF);      sgn = sh[15]; end
      WORD:    begin keep = DW'(64'hFFFF_FFFF); sgn = sh[31]; end
      default: begin keep = '1;                 sgn = 1'b0;   end
    endcase
    data = (sh & keep) | ((sgn && !is_unsigned) ? ~keep : '0);
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: valid/ready request/response, fixed latency, sub-word access.
// Define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter  int DATA_WIDTH_POW = 6,
  parameter  int ADDR_WIDTH_POW = 6,
  parameter  int DEPTH_POW      = 10,
  parameter  int LATENCY        = 1,
  localparam int DW             = 2**DATA_WIDTH_POW,
  localparam int AW             = 2**ADDR_WIDTH_POW,
  localparam int BOFF           = DATA_WIDTH_POW - 3,
  localparam int NB             = DW / 8,
  localparam int HI             = DEPTH_POW + BOFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q;
  logic             err_q;

  logic [DW-1:0]        mem [2**DEPTH_POW];
  logic                 acc, oor, mis, dbl, fault;
  mem_size_e            sz;
  logic [2:0]           off3, off_eff3, smask;
  logic [BOFF-1:0]      off_eff;
  logic [DEPTH_POW-1:0] idx;
  logic [7:0]           be;
  logic [DW-1:0]        wshift, ld_data;

  assign acc   = req_valid && req_ready;
  assign sz    = mem_size_e'(req_size);
  assign off3  = 3'(req_addr[BOFF-1:0]);
  assign smask = size_mask(sz);
  assign idx   = req_addr[HI-1:BOFF];

  if (HI < AW) begin : g_range
    assign oor = |req_addr[AW-1:HI];
  end else begin : g_norange
    assign oor = 1'b0;
  end

  assign dbl = (sz == DOUBLE) && (DW == 32);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign mis      = |(off3 & smask);
  assign off_eff3 = off3;
`else
  assign mis      = 1'b0;
  assign off_eff3 = off3 & ~smask;
`endif

  assign fault   = oor || dbl || mis;
  assign off_eff = off_eff3[BOFF-1:0];
  assign be      = byte_en(sz, off_eff3);
  assign wshift  = req_wdata << {off_eff, 3'b000};

  // Array has no reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (acc && req_write && !fault)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
  end

  data_mem_extract #(.DATA_WIDTH_POW(DATA_WIDTH_POW)) u_extract (
    .word        (mem[idx]),
    .off         (off_eff),
    .size        (sz),
    .is_unsigned (req_unsigned),
    .data        (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        err_q   <= fault;
        rdata_q <= (fault || req_write) ? '0 : ld_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) state_d = RESP;
        else begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 1, 4, 3), vector table, corner sequences, random vs byte model.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n, req_valid, rsp_ready;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata [3];
  logic        req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  int nerr = 0;
  int nchk = 0;

  // Byte-addressed reference memory for instances 0 and 1 (in-range space is 8 KiB).
  logic [7:0] mdl [2][8192];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl #(.LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 3))) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction on instance k; checks latency, busy ready, hold stability, post-handshake ready.
  task automatic xact(input int k, input bit wr, input logic [63:0] addr, input logic [1:0] sz,
                      input bit uns, input logic [63:0] wd, input int hold,
                      output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready[k]), 64'd1);
    req_write = wr; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    // Later changes to request inputs must be ignored.
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_write = 1'($urandom);
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      chk("req_ready_busy", 64'(req_ready[k]), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat_of(k)));
    chk("req_ready_resp", 64'(req_ready[k]), 64'd0);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid[k]), 64'd1);
      chk("hold_data", rsp_rdata[k], rd);
      chk("hold_err", 64'(rsp_err[k]), 64'(er));
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("req_ready_after_hs", 64'(req_ready[k]), 64'd1);
    chk("rsp_valid_after_hs", 64'(rsp_valid[k]), 64'd0);
  endtask

  // Reference: byte memory, little-endian lanes, alignment and range rules as plain arithmetic.
  task automatic model(input int k, input bit wr, input logic [63:0] addr, input logic [1:0] sz,
                       input bit uns, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
    int nb;
    logic [63:0] a;
    nb = 1 << sz;
    rd = '0;
    er = 1'b0;
    if (addr >= 64'h2000) er = 1'b1;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if (addr % nb != 0) er = 1'b1;
`endif
    if (er) return;
    a = addr - (addr % nb);
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[k][a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd |= 64'(mdl[k][a + i]) << (8*i);
      if (!uns && rd[8*nb-1]) rd |= ~((64'd1 << (8*nb)) - 64'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [1:0]  sz;
    bit          uns;
    logic [63:0] wd;
    logic [63:0] exp;
    bit          err;
  } vec_t;

  vec_t tv [17];

  initial begin
    logic [63:0] rd, erd;
    logic        er, eer;
    logic [63:0] addr;
    bit          wr, uns, seen;
    logic [1:0]  sz;
    logic [63:0] wd;

    rst_n = '0; req_valid = '0; rsp_ready = '0;
    req_write = 0; req_addr = '0; req_size = '0; req_unsigned = 0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 64'(req_ready[k]), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata[k], 64'd0);
      chk("rst_rsp_err", 64'(rsp_err[k]), 64'd0);
    end

    // Directed vectors on the LATENCY=1 instance.
    tv[0]  = '{1, 64'h40,   2'd3, 0, 64'h1122334455667788, 64'h0, 0};
    tv[1]  = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334455667788, 0};
    tv[2]  = '{1, 64'h43,   2'd0, 0, 64'hAAAAAAAAAAAAAA80, 64'h0, 0};
    tv[3]  = '{0, 64'h43,   2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0};
    tv[4]  = '{0, 64'h43,   2'd0, 1, 64'h0, 64'h80, 0};
    tv[5]  = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0};
    tv[6]  = '{0, 64'h46,   2'd1, 0, 64'h0, 64'h1122, 0};
    tv[7]  = '{0, 64'h44,   2'd2, 1, 64'h0, 64'h11223344, 0};
    tv[8]  = '{0, 64'h42,   2'd1, 0, 64'h0, 64'hFFFFFFFFFFFF8066, 0};
    tv[9]  = '{0, 64'h2000, 2'd3, 0, 64'h0, 64'h0, 1};
    tv[10] = '{1, 64'h2040, 2'd3, 0, 64'hDEADBEEFCAFEF00D, 64'h0, 1};
    tv[11] = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0};
    tv[15] = '{1, 64'h8000000000000040, 2'd2, 0, 64'h55555555, 64'h0, 1};
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    tv[12] = '{1, 64'h41,   2'd1, 0, 64'h123456789ABCBEEF, 64'h0, 1};
    tv[13] = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0};
    tv[14] = '{0, 64'h42,   2'd2, 0, 64'h0, 64'h0, 1};
    tv[16] = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h1122334480667788, 0};
`else
    tv[12] = '{1, 64'h41,   2'd1, 0, 64'h123456789ABCBEEF, 64'h0, 0};
    tv[13] = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h112233448066BEEF, 0};
    tv[14] = '{0, 64'h42,   2'd2, 0, 64'h0, 64'hFFFFFFFF8066BEEF, 0};
    tv[16] = '{0, 64'h40,   2'd3, 0, 64'h0, 64'h112233448066BEEF, 0};
`endif
    for (int i = 0; i < 17; i++) begin
      xact(0, tv[i].wr, tv[i].addr, tv[i].sz, tv[i].uns, tv[i].wd, i % 3, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tv[i].err));
    end

    // LATENCY=4 with three cycles of back-pressure.
    xact(1, 1, 64'h100, 2'd3, 0, 64'h0123456789ABCDEF, 0, rd, er);
    chk("lat4_store_err", 64'(er), 64'd0);
    xact(1, 0, 64'h100, 2'd3, 0, 64'h0, 3, rd, er);
    chk("lat4_load_data", rd, 64'h0123456789ABCDEF);
    chk("lat4_load_err", 64'(er), 64'd0);

    // Reset in WAIT on the LATENCY=3 instance.
    xact(2, 1, 64'h80, 2'd3, 0, 64'hA5A55A5A0F0FF0F0, 0, rd, er);
    @(negedge clk);
    req_write = 0; req_addr = 64'h80; req_size = 2'd3; req_unsigned = 0;
    req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("wait_rsp_valid", 64'(rsp_valid[2]), 64'd0);
    chk("wait_req_ready", 64'(req_ready[2]), 64'd0);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("rstmid_rsp_valid", 64'(rsp_valid[2]), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready[2]), 64'd1);
    chk("rstmid_rsp_rdata", rsp_rdata[2], 64'd0);
    chk("rstmid_rsp_err", 64'(rsp_err[2]), 64'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);
    xact(2, 0, 64'h80, 2'd3, 0, 64'h0, 1, rd, er);
    chk("store_survives_rst", rd, 64'hA5A55A5A0F0FF0F0);

    // Random traffic against the byte model; window pre-filled so every load is defined.
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a += 8) begin
        wd = {$urandom, $urandom};
        model(k, 1, 64'(a), 2'd3, 0, wd, erd, eer);
        xact(k, 1, 64'(a), 2'd3, 0, wd, 0, rd, er);
        chk("init_err", 64'(er), 64'(eer));
      end
      for (int t = 0; t < 150; t++) begin
        case ($urandom_range(0, 9))
          0:       addr = 64'h2000 + 64'($urandom_range(0, 255));
          1:       addr = (64'd1 << $urandom_range(13, 63)) | 64'($urandom_range(0, 255));
          default: addr = 64'($urandom_range(0, 255));
        endcase
        wr  = 1'($urandom);
        uns = 1'($urandom);
        sz  = 2'($urandom);
        wd  = {$urandom, $urandom};
        model(k, wr, addr, sz, uns, wd, erd, eer);
        xact(k, wr, addr, sz, uns, wd, $urandom_range(0, 2), rd, er);
        chk($sformatf("rnd%0d_%0d_rdata", k, t), rd, erd);
        chk($sformatf("rnd%0d_%0d_err", k, t), 64'(er), 64'(eer));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller for the RISC-V core's load/store path. It supersedes the flat data-memory port with a valid/ready request/response handshake, configurable access latency, and sub-word (byte/half/word/double) loads and stores with sign or zero extension. It holds the data array internally and reports out-of-range and misaligned accesses on the response channel.

## Interface
Parameters:
- DATA_WIDTH_POW, 6, log2 of data width (DATA_WIDTH = 2**DATA_WIDTH_POW; legal values 5 and 6).
- ADDR_WIDTH_POW, 6, log2 of address width (ADDR_WIDTH = 2**ADDR_WIDTH_POW).
- DEPTH_POW, 10, log2 of number of DATA_WIDTH-bit words in the array.
- LATENCY, 1, cycles from request acceptance to rsp_valid (legal values 1 to 15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (low bits used).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted (out of range or misaligned).

## Operation
- Let BOFF = DATA_WIDTH_POW-3. Word index = req_addr[DEPTH_POW+BOFF-1:BOFF]. Lane offset = req_addr[BOFF-1:0].
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid & req_ready, latch the request and evaluate the fault condition. If LATENCY == 1, go to RESP; otherwise load cnt = LATENCY-1 and go to WAIT.
- WAIT: decrement cnt each cycle. When cnt == 1, go to RESP.
- RESP: rsp_valid = 1, with rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE.
- Fault conditions:
  - req_addr bits at or above DEPTH_POW+BOFF are nonzero.
  - req_size == 11 with DATA_WIDTH == 32.
  - Misalignment (see Configuration).
- A faulted request never writes the array. rsp_err = 1 and rsp_rdata = 0.
- Store: byte-enabled write of the low 8/16/32/64 bits of req_wdata into the addressed lanes. It is committed on the acceptance edge; other lanes are unchanged.
- Load: array read at the acceptance edge; lanes are selected by offset, then sign- or zero-extended to DATA_WIDTH. A store followed by a load to the same address returns the new data.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0.
- rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- Back-pressure: RESP holds indefinitely while rsp_ready = 0.
- No overlap between transactions. req_ready returns to 1 on the cycle after the rsp handshake. Peak throughput is one access per LATENCY+1 cycles.
- Request inputs are sampled only at acceptance; changes in later cycles are ignored.
- Reset asserted mid-transaction returns all state to reset values immediately and drops the pending response. A store already committed remains in the array.

## Configuration
- DATA_MEM_MISALIGN_TRAP_EN defined: an access whose lane offset is not a multiple of its size is a fault (rsp_err = 1, no write).
- Undefined: the low log2(size) offset bits are forced to zero, the access completes aligned, and rsp_err never reflects alignment.

## Structure
- Package data_mem_pkg holds:
  - mem_size_e (BYTE, HALF, WORD, DOUBLE).
  - ctrl_state_e (IDLE, WAIT, RESP).
  - A function computing the byte-enable mask from size and offset.
- Sub-module data_mem_extract: combinational lane select plus sign/zero extension, parametrised by DATA_WIDTH_POW. It is instantiated once on the read path.

## Test plan
- Defaults, LATENCY=1: store double 0x1122334455667788 at 0x40, then load double at 0x40 → rsp_valid one cycle after acceptance, rsp_rdata 0x1122334455667788, rsp_err 0.
- Sub-word: store byte 0x80 at 0x43, then load byte signed at 0x43 → 0xFFFFFFFFFFFFFF80. Load unsigned → 0x80. Load double at 0x40 → 0x1122334480667788.
- LATENCY=4 with rsp_ready held low for 3 cycles → rsp_valid rises at acceptance+4, data stable throughout, req_ready stays 0 until the cycle after the handshake.
- Out of range: load at address 1<<13 with DEPTH_POW=10 → rsp_err 1, rsp_rdata 0. A store at the same address leaves the array unchanged.
- Misaligned half store at 0x41 → with DATA_MEM_MISALIGN_TRAP_EN: rsp_err 1, no write. Without it: data written at 0x40 and 0x41, rsp_err 0.
- rst_n pulled low while in WAIT (LATENCY=3) → rsp_valid 0 and req_ready 1 immediately, no response after release, and an earlier committed store still reads back.
